// File: rtl/legv8_cw_engine.sv
// Multi-cycle LEGv8 control-word engine: accepts one decoded control word per
// valid/ready handshake and sequences it through EXEC, optional MEM, and WB.
module legv8_cw_engine #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              RST,
  input  logic              cw_valid,
  output logic              cw_ready,
  input  logic [REG_AW-1:0] cw_da,
  input  logic [REG_AW-1:0] cw_aa,
  input  logic [REG_AW-1:0] cw_ba,
  input  logic [2:0]        cw_fs,
  input  logic [DATA_W-1:0] cw_k,
  input  logic              cw_bsel,
  input  logic              cw_wr,
  input  logic [1:0]        cw_dsrc,
  input  logic [1:0]        cw_mem,
  input  logic [1:0]        cw_ps,
  input  logic [1:0]        cw_cond,
  input  logic              cw_stat,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        status,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int NREG = 2**REG_AW;
  localparam logic [REG_AW-1:0] XZR = {REG_AW{1'b1}};
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [NREG];

  logic [REG_AW-1:0] da_q, aa_q, ba_q;
  logic [2:0]        fs_q;
  logic [DATA_W-1:0] k_q;
  logic              bsel_q, wr_q, stat_q;
  logic [1:0]        dsrc_q, mem_q, ps_q, cond_q;

  logic [DATA_W-1:0] alu_q, b_q, ld_q;
  logic [ADDR_W-1:0] a_q, pc_q;
  logic [3:0]        nzcv;

  logic [DATA_W-1:0] rd_a, rd_b, op_b, alu_res, wb_data;
  logic [DATA_W+1:0] alu_out;
  logic              alu_c, alu_v, taken;
  logic [ADDR_W-1:0] pc_plus4, pc_nxt;
  logic signed [ADDR_W-1:0] br_off;

  // Returns {carry, overflow, result}; C and V stay 0 outside ADD/SUB.
  function automatic logic [DATA_W+1:0] alu(input logic [2:0] fs,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] r;
    logic              c, v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (fs)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      3'd4: begin
        sum = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
        r   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      end
      3'd5: r = a << b[SH_W-1:0];
      3'd6: r = a >> b[SH_W-1:0];
      default: r = b;
    endcase
    return {c, v, r};
  endfunction

  assign rd_a    = (aa_q == XZR) ? '0 : regs[aa_q];
  assign rd_b    = (ba_q == XZR) ? '0 : regs[ba_q];
  assign op_b    = bsel_q ? k_q : rd_b;
  assign alu_out = alu(fs_q, rd_a, op_b);
  assign alu_res = alu_out[DATA_W-1:0];
  assign alu_v   = alu_out[DATA_W];
  assign alu_c   = alu_out[DATA_W+1];

  // Branch offset is K sign-extended and scaled to a word offset.
  assign br_off   = $signed(k_q[ADDR_W-1:0]) <<< 2;
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    taken = 1'b1;
    case (cond_q)
      2'd1:    taken = nzcv[2];
      2'd2:    taken = ~nzcv[2];
      2'd3:    taken = nzcv[3] ^ nzcv[0];
      default: taken = 1'b1;
    endcase
    pc_nxt = pc_q;
    case (ps_q)
      2'd1:    pc_nxt = pc_plus4;
      2'd2:    pc_nxt = taken ? (pc_q + $unsigned(br_off)) : pc_plus4;
      2'd3:    pc_nxt = a_q;
      default: pc_nxt = pc_q;
    endcase
    wb_data = alu_q;
    case (dsrc_q)
      2'd1:    wb_data = b_q;
      2'd2:    wb_data = DATA_W'(pc_plus4);
      2'd3:    wb_data = ld_q;
      default: wb_data = alu_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cw_valid) state_nxt = EXEC;
      EXEC:    state_nxt = (mem_q == 2'd1 || mem_q == 2'd2) ? MEM : WB;
      MEM:     if (mem_ack) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!RST) begin
      da_q   <= '0;
      aa_q   <= '0;
      ba_q   <= '0;
      fs_q   <= '0;
      k_q    <= '0;
      bsel_q <= 1'b0;
      wr_q   <= 1'b0;
      stat_q <= 1'b0;
      dsrc_q <= '0;
      mem_q  <= '0;
      ps_q   <= '0;
      cond_q <= '0;
      alu_q  <= '0;
      b_q    <= '0;
      ld_q   <= '0;
      a_q    <= '0;
      pc_q   <= '0;
      nzcv   <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (cw_valid) begin
          da_q   <= cw_da;
          aa_q   <= cw_aa;
          ba_q   <= cw_ba;
          fs_q   <= cw_fs;
          k_q    <= cw_k;
          bsel_q <= cw_bsel;
          wr_q   <= cw_wr;
          stat_q <= cw_stat;
          dsrc_q <= cw_dsrc;
          mem_q  <= cw_mem;
          ps_q   <= cw_ps;
          cond_q <= cw_cond;
        end
        EXEC: begin
          alu_q <= alu_res;
          b_q   <= rd_b;
          a_q   <= rd_a[ADDR_W-1:0];
          if (stat_q) nzcv <= {alu_res[DATA_W-1], alu_res == '0, alu_c, alu_v};
        end
        MEM: if (mem_ack) ld_q <= mem_rdata;
        WB: begin
          if (wr_q && da_q != XZR) regs[da_q] <= wb_data;
          pc_q <= pc_nxt;
        end
        default: ;
      endcase
    end
  end

  // Memory port is driven straight from EXEC results, so it is stable for all of MEM.
  assign mem_req   = (state == MEM);
  assign mem_we    = mem_req && (mem_q == 2'd2);
  assign mem_addr  = alu_q[ADDR_W-1:0];
  assign mem_wdata = b_q;

  assign cw_ready = (state == IDLE);
  assign busy     = ~cw_ready;
  assign pc       = pc_q;
  assign status   = nzcv;
  assign dbg_data = (dbg_sel == XZR) ? '0 : regs[dbg_sel];
endmodule

// File: tb/tb_legv8_cw_engine.sv
// Scoreboard bench for legv8_cw_engine: expectations are queued when a control
// word is issued and checked when the engine returns to IDLE.
module tb_legv8_cw_engine;
  localparam int DATA_W = 64;
  localparam int REG_AW = 5;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              RST = 1'b0;
  logic              cw_valid = 1'b0;
  logic              cw_ready;
  logic [REG_AW-1:0] cw_da = '0, cw_aa = '0, cw_ba = '0;
  logic [2:0]        cw_fs = '0;
  logic [DATA_W-1:0] cw_k = '0;
  logic              cw_bsel = 1'b0, cw_wr = 1'b0, cw_stat = 1'b0;
  logic [1:0]        cw_dsrc = '0, cw_mem = '0, cw_ps = '0, cw_cond = '0;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        status;
  logic              busy;
  logic [REG_AW-1:0] dbg_sel = '0;
  logic [DATA_W-1:0] dbg_data;

  legv8_cw_engine #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .RST(RST), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .cw_da(cw_da), .cw_aa(cw_aa), .cw_ba(cw_ba), .cw_fs(cw_fs), .cw_k(cw_k),
    .cw_bsel(cw_bsel), .cw_wr(cw_wr), .cw_dsrc(cw_dsrc), .cw_mem(cw_mem),
    .cw_ps(cw_ps), .cw_cond(cw_cond), .cw_stat(cw_stat),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc), .status(status), .busy(busy),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  da, aa, ba;
    logic [2:0]  fs;
    logic [63:0] k;
    logic        bsel, wr, stat;
    logic [1:0]  dsrc, mem, ps, cond;
  } cw_t;

  typedef struct {
    string       tag;
    int          lat;
    int          mcyc;
    logic [31:0] maddr;
    logic [63:0] mwdata;
    logic        mwe;
    logic [4:0]  ridx;
    logic [63:0] rval;
    logic [31:0] pc;
    logic [3:0]  st;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ram [logic [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cw_t mkcw(input int da, input int aa, input int ba, input int fs,
                               input logic [63:0] k, input int bsel, input int wr,
                               input int dsrc, input int mem, input int ps,
                               input int cond, input int stat);
    cw_t c;
    c.da = 5'(da);     c.aa = 5'(aa);     c.ba = 5'(ba);     c.fs = 3'(fs);
    c.k = k;           c.bsel = 1'(bsel); c.wr = 1'(wr);     c.dsrc = 2'(dsrc);
    c.mem = 2'(mem);   c.ps = 2'(ps);     c.cond = 2'(cond); c.stat = 1'(stat);
    return c;
  endfunction

  function automatic exp_t mkexp(input string tag, input int lat, input int mcyc,
                                 input logic [31:0] maddr, input logic [63:0] mwdata,
                                 input int mwe, input int ridx, input logic [63:0] rval,
                                 input logic [31:0] epc, input int st);
    exp_t e;
    e.tag = tag;     e.lat = lat;       e.mcyc = mcyc;     e.maddr = maddr;
    e.mwdata = mwdata; e.mwe = 1'(mwe); e.ridx = 5'(ridx); e.rval = rval;
    e.pc = epc;      e.st = 4'(st);
    return e;
  endfunction

  task automatic present(input cw_t c);
    cw_da = c.da;     cw_aa = c.aa;     cw_ba = c.ba;     cw_fs = c.fs;
    cw_k = c.k;       cw_bsel = c.bsel; cw_wr = c.wr;     cw_dsrc = c.dsrc;
    cw_mem = c.mem;   cw_ps = c.ps;     cw_cond = c.cond; cw_stat = c.stat;
    cw_valid = 1'b1;
  endtask

  task automatic check_state(input exp_t e);
    dbg_sel = e.ridx;
    #1;
    check({e.tag, "_reg"}, dbg_data, e.rval);
    check({e.tag, "_pc"}, 64'(pc), 64'(e.pc));
    check({e.tag, "_status"}, 64'(status), 64'(e.st));
    check({e.tag, "_busy"}, 64'(busy), 0);
  endtask

  // Issue one word, act as the memory (ack after ack_dly wait cycles), then score it.
  task automatic do_txn(input cw_t c, input int ack_dly, input exp_t e);
    int   lat;
    int   mcyc;
    exp_t x;
    sb.push_back(e);
    @(negedge clock);
    present(c);
    @(posedge clock);
    #1 cw_valid = 1'b0;
    lat  = 1;
    mcyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (cw_ready) break;
      mem_ack = 1'b0;
      if (mem_req) begin
        mcyc++;
        check({e.tag, "_maddr"}, 64'(mem_addr), 64'(e.maddr));
        check({e.tag, "_mwdata"}, mem_wdata, e.mwdata);
        check({e.tag, "_mwe"}, 64'(mem_we), 64'(e.mwe));
        if (mcyc == ack_dly + 1) begin
          mem_ack = 1'b1;
          if (mem_we) ram[mem_addr] = mem_wdata;
          mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : 64'h0;
        end
      end
      @(posedge clock);
      lat++;
    end
    mem_ack = 1'b0;
    x = sb.pop_front();
    check({x.tag, "_ready"}, 64'(cw_ready), 1);
    check({x.tag, "_latency"}, 64'(lat), 64'(x.lat));
    check({x.tag, "_memreq_cycles"}, 64'(mcyc), 64'(x.mcyc));
    check_state(x);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    RST = 1'b1;
    dbg_sel = 5'd1;
    #1;
    check("rst_ready", 64'(cw_ready), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_mem_req", 64'(mem_req), 0);
    check("rst_mem_we", 64'(mem_we), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_dbg", dbg_data, 0);
    check("rst_pc", 64'(pc), 0);
    check("rst_status", 64'(status), 0);

    // ALU, flags and PC sequencing
    do_txn(mkcw(1, 31, 31, 7, 5, 1, 1, 0, 0, 1, 0, 0), 0, mkexp("x1_5", 3, 0, 0, 0, 0, 1, 5, 4, 'b0000));
    do_txn(mkcw(2, 1, 31, 3, 7, 1, 1, 0, 0, 1, 0, 1), 0, mkexp("add", 3, 0, 0, 0, 0, 2, 12, 8, 'b0000));
    do_txn(mkcw(1, 31, 31, 7, 3, 1, 1, 0, 0, 1, 0, 0), 0, mkexp("x1_3", 3, 0, 0, 0, 0, 1, 3, 12, 'b0000));
    do_txn(mkcw(3, 1, 31, 4, 3, 1, 1, 0, 0, 1, 0, 1), 0, mkexp("sub_z", 3, 0, 0, 0, 0, 3, 0, 16, 'b0110));
    do_txn(mkcw(0, 31, 31, 7, 4, 1, 0, 0, 0, 2, 1, 0), 0, mkexp("bz_taken", 3, 0, 0, 0, 0, 3, 0, 32, 'b0110));
    do_txn(mkcw(0, 31, 31, 7, 4, 1, 0, 0, 0, 2, 2, 0), 0, mkexp("bnz_not", 3, 0, 0, 0, 0, 3, 0, 36, 'b0110));
    do_txn(mkcw(1, 31, 31, 7, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 1, 0, 0), 0,
           mkexp("x1_max", 3, 0, 0, 0, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 40, 'b0110));
    do_txn(mkcw(5, 1, 31, 3, 1, 1, 1, 0, 0, 1, 0, 1), 0,
           mkexp("add_ovf", 3, 0, 0, 0, 0, 5, 64'h8000_0000_0000_0000, 44, 'b1001));
    do_txn(mkcw(31, 31, 31, 7, 64'h1234, 1, 1, 0, 0, 1, 0, 0), 0, mkexp("xzr", 3, 0, 0, 0, 0, 31, 0, 48, 'b1001));

    // Store then load through the req/ack port
    do_txn(mkcw(6, 31, 31, 7, 64'hDEAD, 1, 1, 0, 0, 1, 0, 0), 0, mkexp("x6", 3, 0, 0, 0, 0, 6, 64'hDEAD, 52, 'b1001));
    do_txn(mkcw(0, 31, 6, 3, 64'h40, 1, 0, 0, 2, 1, 0, 0), 3,
           mkexp("store", 7, 4, 32'h40, 64'hDEAD, 1, 6, 64'hDEAD, 56, 'b1001));
    do_txn(mkcw(4, 31, 31, 3, 64'h40, 1, 1, 3, 1, 1, 0, 0), 3,
           mkexp("load", 7, 4, 32'h40, 0, 0, 4, 64'hDEAD, 60, 'b1001));

    // Link and jump, remaining ALU ops, backward branch
    do_txn(mkcw(7, 2, 31, 7, 0, 1, 1, 2, 0, 3, 0, 0), 0, mkexp("link_jump", 3, 0, 0, 0, 0, 7, 64, 12, 'b1001));
    do_txn(mkcw(10, 2, 31, 5, 4, 1, 1, 0, 0, 1, 0, 0), 0, mkexp("lsl", 3, 0, 0, 0, 0, 10, 192, 16, 'b1001));
    do_txn(mkcw(11, 10, 31, 6, 2, 1, 1, 0, 0, 1, 0, 0), 0, mkexp("lsr", 3, 0, 0, 0, 0, 11, 48, 20, 'b1001));
    do_txn(mkcw(12, 2, 31, 2, 64'hFF, 1, 1, 0, 0, 1, 0, 0), 0, mkexp("xor", 3, 0, 0, 0, 0, 12, 243, 24, 'b1001));
    do_txn(mkcw(13, 2, 31, 0, 6, 1, 1, 0, 0, 1, 0, 1), 0, mkexp("and_flags", 3, 0, 0, 0, 0, 13, 4, 28, 'b0000));
    do_txn(mkcw(14, 2, 31, 1, 3, 1, 1, 0, 0, 1, 0, 0), 0, mkexp("or", 3, 0, 0, 0, 0, 14, 15, 32, 'b0000));
    do_txn(mkcw(15, 2, 31, 4, 13, 1, 1, 0, 0, 1, 0, 1), 0,
           mkexp("sub_borrow", 3, 0, 0, 0, 0, 15, 64'hFFFF_FFFF_FFFF_FFFF, 36, 'b1000));
    do_txn(mkcw(16, 2, 15, 3, 0, 0, 1, 0, 0, 1, 0, 1), 0, mkexp("add_regb", 3, 0, 0, 0, 0, 16, 11, 40, 'b0010));
    do_txn(mkcw(0, 31, 31, 7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0, 2, 0, 0), 0,
           mkexp("branch_back", 3, 0, 0, 0, 0, 16, 11, 32, 'b0010));

    // Handshake: valid held high with a new word every cycle, stray mem_ack throughout
    sb.push_back(mkexp("handshake", 0, 0, 0, 0, 0, 8, 64'h103, 40, 'b0010));
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      present(mkcw(8, 31, 31, 7, 64'h100 + 64'(i), 1, 1, 0, 0, 1, 0, 0));
      #1 check("hs_ready", 64'(cw_ready), 64'(i % 3 == 0));
    end
    @(negedge clock);
    cw_valid = 1'b0;
    mem_ack  = 1'b0;
    @(negedge clock);
    check("hs_idle", 64'(cw_ready), 1);
    x = sb.pop_front();
    check_state(x);

    // Reset while a load is waiting for its ack
    @(negedge clock);
    present(mkcw(9, 31, 31, 3, 64'h40, 1, 1, 3, 1, 1, 0, 0));
    @(posedge clock);
    #1 cw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mem_req) break;
    end
    check("rm_req_high", 64'(mem_req), 1);
    RST = 1'b0;
    @(posedge clock);
    #1;
    check("rm_req_low", 64'(mem_req), 0);
    check("rm_we_low", 64'(mem_we), 0);
    check("rm_pc", 64'(pc), 0);
    check("rm_ready", 64'(cw_ready), 1);
    check("rm_status", 64'(status), 0);
    @(negedge clock);
    RST = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 64'h55;
    repeat (3) @(posedge clock);
    #1 mem_ack = 1'b0;
    @(negedge clock);
    dbg_sel = 5'd9;
    #1 check("rm_late_ack_x9", dbg_data, 0);
    dbg_sel = 5'd2;
    #1 check("rm_cleared_x2", dbg_data, 0);
    check("rm_pc_after", 64'(pc), 0);
    check("rm_idle_after", 64'(cw_ready), 1);
    check("rm_req_after", 64'(mem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
